// File: rtl/hrnode_param_pkg.sv
// Shared flit layout and helpers for the hierarchical-ring node.
// Optional feature macro used by the node: HRNODE_EJ_BP_EN.
package hrnode_param_pkg;

  localparam int unsigned control_w    = 144;
  localparam int unsigned HR_FLIT_W    = control_w;
  localparam int unsigned HR_VALID_BIT = 4;
  localparam int unsigned HR_DEST_LSB  = 0;
  localparam int unsigned HR_DEST_W    = 4;

  typedef logic [HR_DEST_W-1:0] hr_dest_t;

  function automatic hr_dest_t hr_dest(input logic [HR_VALID_BIT:0] lo);
    return lo[HR_DEST_LSB +: HR_DEST_W];
  endfunction

endpackage

// File: rtl/hrnode_param_injq.sv
// Per-channel local injection FIFO (power-of-two depth, no bypass).
module hrnode_injq
  import hrnode_param_pkg::*;
#(
  parameter int unsigned W     = HR_FLIT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/hrnode_param.sv
// Parametrised hierarchical-ring node: per-channel eject / pass / inject.
// Optional ejection back-pressure (portl_rdy) via macro HRNODE_EJ_BP_EN.
module hrnode_param
  import hrnode_param_pkg::*;
#(
  parameter logic [HR_DEST_W-1:0] ADDR   = 4'b0010,
  parameter int unsigned          CH     = 2,
  parameter int unsigned          FLIT_W = HR_FLIT_W,
  parameter int unsigned          QDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*FLIT_W-1:0] port_i,
  input  logic [CH*FLIT_W-1:0] port_local_i,
  output logic [CH*FLIT_W-1:0] port_o,
  output logic [CH*FLIT_W-1:0] port_local_o,
  output logic [CH-1:0]        portl_ack
`ifdef HRNODE_EJ_BP_EN
  ,
  input  logic [CH-1:0]        portl_rdy
`endif
);

  logic [CH-1:0] sink_rdy;

`ifdef HRNODE_EJ_BP_EN
  assign sink_rdy = portl_rdy;
`else
  assign sink_rdy = '1;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [FLIT_W-1:0] ring, loc, head;
    logic [FLIT_W-1:0] out_d, out_q, ej_d, ej_q;
    logic              hit, pass, pop, push, full, empty;

    assign ring = port_i[c*FLIT_W +: FLIT_W];
    assign loc  = port_local_i[c*FLIT_W +: FLIT_W];

    // Ack is held low during reset even though the FIFO already reads not-full.
    assign push         = loc[HR_VALID_BIT] && !full && rst;
    assign portl_ack[c] = push;

    always_comb begin
      hit   = ring[HR_VALID_BIT] && (hr_dest(ring[HR_VALID_BIT:0]) == ADDR) && sink_rdy[c];
      pass  = ring[HR_VALID_BIT] && !hit;
      pop   = !pass && !empty;
      ej_d  = hit ? ring : '0;
      out_d = '0;
      if (pass)     out_d = ring;
      else if (pop) out_d = head;
    end

    hrnode_injq #(
      .W     (FLIT_W),
      .DEPTH (QDEPTH)
    ) u_injq (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (loc),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_q <= '0;
        ej_q  <= '0;
      end else begin
        out_q <= out_d;
        ej_q  <= ej_d;
      end
    end

    assign port_o[c*FLIT_W +: FLIT_W]       = out_q;
    assign port_local_o[c*FLIT_W +: FLIT_W] = ej_q;
  end

endmodule

// File: tb/tb_hrnode_param.sv
// Directed, table-driven self-checking bench for hrnode_param (CH=2, ADDR=2).
module tb_hrnode_param;

  localparam int unsigned FW = 144;
  localparam int unsigned CH = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [CH*FW-1:0]   port_i, port_local_i, port_o, port_local_o;
  logic [CH-1:0]      ack;
`ifdef HRNODE_EJ_BP_EN
  logic [CH-1:0]      rdy = '1;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  hrnode_param #(
    .ADDR   (4'b0010),
    .CH     (CH),
    .FLIT_W (FW),
    .QDEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .port_i       (port_i),
    .port_local_i (port_local_i),
    .port_o       (port_o),
    .port_local_o (port_local_o),
    .portl_ack    (ack)
`ifdef HRNODE_EJ_BP_EN
    ,
    .portl_rdy    (rdy)
`endif
  );

  function automatic logic [FW-1:0] mk(input logic [7:0] tag, input logic [15:0] lo);
    return {tag, {15{tag}}, lo};
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [FW-1:0] p0, input logic [FW-1:0] p1,
                       input logic [FW-1:0] l0, input logic [FW-1:0] l1);
    port_i       = {p1, p0};
    port_local_i = {l1, l0};
  endtask

  function automatic logic [FW-1:0] o_ch(input int unsigned c);
    return port_o[c*FW +: FW];
  endfunction

  function automatic logic [FW-1:0] l_ch(input int unsigned c);
    return port_local_o[c*FW +: FW];
  endfunction

  typedef struct {
    logic [FW-1:0] p0, p1, l0, l1;
    logic [1:0]    ack;
    logic [FW-1:0] o0, o1, e0, e1;
  } vec_t;

  vec_t vt [7];

  // One cycle: drive at negedge, check ack, clock, check registered outputs.
  task automatic step(input string tag, input logic [FW-1:0] p0, input logic [FW-1:0] l0,
                      input logic exp_ack0, input logic [FW-1:0] exp_o0);
    @(negedge clk);
    drive(p0, '0, l0, '0);
    #1 chk({tag, "_ack0"}, FW'(ack[0]), FW'(exp_ack0));
    @(posedge clk);
    #1 chk({tag, "_o0"}, o_ch(0), exp_o0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] E1, P1, L1, E2, P2, L2, P3, C3, z;
    logic [FW-1:0] Q [5];
    logic [FW-1:0] M [4];
    logic [FW-1:0] S;

    z  = '0;
    E1 = mk(8'hA1, 16'h1852);  P1 = mk(8'hB1, 16'h1855);
    L1 = mk(8'hC1, 16'h1851);  E2 = mk(8'hA2, 16'h1852);
    P2 = mk(8'hB2, 16'h1855);  L2 = mk(8'hC2, 16'h1851);
    P3 = mk(8'hB3, 16'h1855);  C3 = mk(8'hC3, 16'h1852);

    //           p0  p1  l0  l1  ack    o0  o1  e0  e1
    vt[0] = '{E1, P1, z,  z,  2'b00, z,  P1, E1, z};
    vt[1] = '{z,  z,  L1, z,  2'b01, z,  z,  z,  z};
    vt[2] = '{E2, P2, z,  L2, 2'b10, L1, P2, E2, z};
    vt[3] = '{z,  P3, z,  z,  2'b00, z,  P3, z,  z};
    vt[4] = '{z,  z,  z,  z,  2'b00, z,  L2, z,  z};
    vt[5] = '{z,  z,  C3, z,  2'b01, z,  z,  z,  z};
    vt[6] = '{z,  z,  z,  z,  2'b00, C3, z,  z,  z};

    // Reset state, with a local flit presented so ack gating is visible.
    rst_n = 1'b0;
    drive(z, z, L1, L2);
    #1;
    chk("rst_ack", FW'(ack), FW'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o0", o_ch(0), z);
    chk("rst_o1", o_ch(1), z);
    chk("rst_e0", l_ch(0), z);
    @(negedge clk);
    drive(z, z, z, z);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vt[i].p0, vt[i].p1, vt[i].l0, vt[i].l1);
      #1 chk($sformatf("v%0d_ack", i), FW'(ack), FW'(vt[i].ack));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_o0", i), o_ch(0), vt[i].o0);
      chk($sformatf("v%0d_o1", i), o_ch(1), vt[i].o1);
      chk($sformatf("v%0d_e0", i), l_ch(0), vt[i].e0);
      chk($sformatf("v%0d_e1", i), l_ch(1), vt[i].e1);
    end

    // Full: ring saturated with dest=5 traffic, five pushes -> acks 1,1,1,1,0.
    for (int k = 0; k < 5; k++) begin
      Q[k] = mk(8'hD0 + 8'(k), 16'h1851);
      S    = mk(8'h50 + 8'(k), 16'h1855);
      step($sformatf("full%0d", k), S, Q[k], (k < 4), S);
    end
    // Release ring while still full: push refused, pop frees entry for next cycle.
    step("rel0", z, Q[4], 1'b0, Q[0]);
    step("rel1", z, Q[4], 1'b1, Q[1]);
    step("rel2", z, z, 1'b0, Q[2]);
    step("rel3", z, z, 1'b0, Q[3]);
    step("rel4", z, z, 1'b0, Q[4]);
    step("rel5", z, z, 1'b0, z);

    // Wrap with simultaneous push/pop on a free ring; no same-cycle bypass.
    for (int k = 0; k < 4; k++) begin
      M[k] = mk(8'hE0 + 8'(k), 16'h1853);
      step($sformatf("wrap%0d", k), z, M[k], 1'b1, (k == 0) ? z : M[k-1]);
    end
    step("wrap4", z, z, 1'b0, M[3]);

    // Mid-operation reset: queue a flit behind ring traffic, then reset.
    step("pre_rst", mk(8'h61, 16'h1855), L1, 1'b1, mk(8'h61, 16'h1855));
    @(negedge clk);
    drive(mk(8'h62, 16'h1855), z, L2, z);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_o0", o_ch(0), z);
    chk("mrst_ack", FW'(ack), FW'(0));
    @(negedge clk);
    drive(z, z, z, z);
    rst_n = 1'b1;
    step("post_rst_empty", z, z, 1'b0, z);
    step("post_rst_push", z, L2, 1'b1, z);
    step("post_rst_out", z, z, 1'b0, L2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
